// File: rtl/lag_pl_status.sv
// lag_pl_status: output-port lane-status tracker for physical-lane allocation.
// Each output port owns nv lanes. Every lane runs an IDLE/BUSY/DRAIN ownership
// FSM and keeps a downstream credit counter. The allocator gets back per-lane
// free/credit status and a one-cycle per-port "allocation accepted" pulse.
// Protocol violations are ignored but recorded in a sticky err flag.
// Optional feature macro: LAG_PL_EARLY_RELEASE_EN. When it is defined, a lane
// returns to IDLE on its tail flit without waiting for outstanding credits.
module lag_pl_status #(
  parameter int np      = 5,
  parameter int nv      = 4,
  parameter int buf_len = 4,
  localparam int cw     = $clog2(buf_len + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [np-1:0][nv-1:0]           alloc,
  input  logic [np-1:0][nv-1:0]           flit_sent,
  input  logic [np-1:0][nv-1:0]           flit_tail,
  input  logic [np-1:0][nv-1:0]           credit_in,
  output logic [np-1:0][nv-1:0]           pl_free,
  output logic [np-1:0][nv-1:0]           pl_credit,
  output logic [np-1:0]                   pl_allocated,
  output logic [np-1:0][nv-1:0][cw-1:0]   credit_cnt,
  output logic                            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } lane_state_t;

  // The state a lane enters when its tail flit departs.
`ifdef LAG_PL_EARLY_RELEASE_EN
  localparam lane_state_t TAIL_NEXT = IDLE;
`else
  localparam lane_state_t TAIL_NEXT = DRAIN;
`endif

  localparam logic [cw-1:0] FULL = cw'(buf_len);

  lane_state_t             state   [np][nv];
  logic        [cw-1:0]    cnt     [np][nv];
  logic        [cw-1:0]    cnt_nxt [np][nv];

  logic [np-1:0]           multi;
  logic [np-1:0]           alloc_hit;
  logic [np-1:0][nv-1:0]   alloc_ok;
  logic [np-1:0][nv-1:0]   sent_ok;
  logic                    err_ev;

  // Qualify incoming events against current lane state, detect violations and
  // compute each lane's next credit count.
  always_comb begin
    err_ev    = 1'b0;
    alloc_hit = '0;
    multi     = '0;
    alloc_ok  = '0;
    sent_ok   = '0;
    for (int op = 0; op < np; op++) begin
      // A port presenting several grants at once is rejected as a whole.
      multi[op] = ($countones(alloc[op]) > 1);
      if (multi[op]) err_ev = 1'b1;
      for (int l = 0; l < nv; l++) begin
        cnt_nxt[op][l]  = cnt[op][l];
        alloc_ok[op][l] = alloc[op][l] & ~multi[op];
        if (alloc_ok[op][l]) begin
          if (state[op][l] == IDLE) alloc_hit[op] = 1'b1;
          else                      err_ev        = 1'b1;
        end
        // Only a lane that currently carries a packet may forward flits.
        sent_ok[op][l] = flit_sent[op][l] & (state[op][l] == BUSY);
        if (flit_sent[op][l] && (state[op][l] != BUSY)) err_ev = 1'b1;
        if (sent_ok[op][l] && !credit_in[op][l]) begin
          if (cnt[op][l] == '0) err_ev = 1'b1;
          else                  cnt_nxt[op][l] = cnt[op][l] - cw'(1);
        end else if (credit_in[op][l] && !sent_ok[op][l]) begin
          if (cnt[op][l] == FULL) err_ev = 1'b1;
          else                    cnt_nxt[op][l] = cnt[op][l] + cw'(1);
        end
      end
    end
  end

  // Lane FSMs, credit counters, the accepted-allocation pulse and sticky err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int op = 0; op < np; op++) begin
        for (int l = 0; l < nv; l++) begin
          state[op][l] <= IDLE;
          cnt[op][l]   <= FULL;
        end
      end
      pl_allocated <= '0;
      err          <= 1'b0;
    end else begin
      pl_allocated <= alloc_hit;
      err          <= err | err_ev;
      for (int op = 0; op < np; op++) begin
        for (int l = 0; l < nv; l++) begin
          cnt[op][l] <= cnt_nxt[op][l];
          case (state[op][l])
            IDLE:    if (alloc_ok[op][l]) state[op][l] <= BUSY;
            BUSY:    if (sent_ok[op][l] && flit_tail[op][l]) state[op][l] <= TAIL_NEXT;
            // Released only once every credit has come home, counting any
            // credit that arrives this very cycle.
            DRAIN:   if (cnt_nxt[op][l] == FULL) state[op][l] <= IDLE;
            default: state[op][l] <= IDLE;
          endcase
        end
      end
    end
  end

  // Status outputs decoded purely from registered state.
  always_comb begin
    for (int op = 0; op < np; op++) begin
      for (int l = 0; l < nv; l++) begin
        pl_free[op][l]    = (state[op][l] == IDLE);
        pl_credit[op][l]  = (cnt[op][l] != '0);
        credit_cnt[op][l] = cnt[op][l];
      end
    end
  end

endmodule

// File: doc/lag_pl_status.md
Name: lag_pl_status

Overview:
- Output-port side of physical-lane allocation: one lane-status tracker per output port, nv lanes each.
- Receives the lane grants issued by the PL allocation arbiter.
- Tracks each lane's ownership and its downstream credit count.
- Releases a lane after its tail flit departs and its credits return.
- Drives back to the allocator the per-lane free/credit status and the per-port pl_allocated success flag.

Parameters:
np, 5, number of router ports
nv, 4, lanes per port
buf_len, 4, downstream buffer depth per lane (initial credit count); cw = clog2(buf_len+1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
alloc  input  [np-1:0][nv-1:0]  lane [op][l] granted to a packet this cycle (one-hot per op)
flit_sent  input  [np-1:0][nv-1:0]  flit forwarded on lane [op][l] this cycle
flit_tail  input  [np-1:0][nv-1:0]  qualifies flit_sent: flit is tail
credit_in  input  [np-1:0][nv-1:0]  credit returned from downstream for lane [op][l]
pl_free  output  [np-1:0][nv-1:0]  lane is IDLE and allocatable
pl_credit  output  [np-1:0][nv-1:0]  lane credit count > 0
pl_allocated  output  [np-1:0]  registered: a valid alloc was accepted on port op last cycle
credit_cnt  output  [np-1:0][nv-1:0][cw-1:0]  current credit counters
err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n low):
  - all lanes IDLE; credit_cnt = buf_len.
  - pl_free all 1; pl_credit all 1; pl_allocated 0; err 0.
- Per-lane FSM, states IDLE, BUSY, DRAIN:
  - IDLE -> BUSY on alloc.
  - BUSY -> DRAIN on flit_sent & flit_tail.
  - DRAIN -> IDLE when credit_cnt == buf_len, after this cycle's credit update. A credit arriving in the final cycle frees the lane at the next edge.
  - DRAIN -> BUSY never; alloc while DRAIN is an error.
- pl_free = (state == IDLE), decoded from registers with no input-to-output combinational path.
  - alloc at edge t: pl_free low from t+1.
- Credit counter, per lane, each cycle:
  - flit_sent only: decrement.
  - credit_in only: increment.
  - both: unchanged.
  - Saturating guards: flit_sent at 0 -> counter held, err set. credit_in at buf_len (with no simultaneous flit_sent) -> counter held, err set.
- pl_credit = (credit_cnt != 0).
- pl_allocated[op]: register set for one cycle when any alloc[op][*] hits an IDLE lane; 0 otherwise.
- Further err conditions; in each case the offending event is ignored:
  - alloc on a non-IDLE lane; state unchanged.
  - more than one alloc bit set in alloc[op]; all allocs on that port ignored that cycle.
  - flit_sent on an IDLE or DRAIN lane; counter unchanged.
- Single-flit packet: alloc at t, head+tail flit_sent at t+1 -> BUSY -> DRAIN.
- Simultaneous events:
  - alloc and flit_sent on the same lane in the same cycle while IDLE: alloc accepted, flit_sent treated as error.
  - Lanes are fully independent; events on different lanes never interact.
- err is cleared only by reset.
- Reset mid-packet: all state returns to reset values immediately and asynchronously. No drain is performed.

Optional Feature:
LAG_PL_EARLY_RELEASE_EN
- Defined:
  - BUSY -> IDLE directly on tail; DRAIN is unreachable.
  - Lane reallocatable while credits are outstanding; credit_cnt keeps tracking them.
  - Allocator relies on pl_credit for flow control.
- Undefined: DRAIN behaviour as specified above.

Test Plan:
- Reset, then idle 3 cycles -> pl_free = all 1, credit_cnt = 4 every lane, pl_allocated = 0, err = 0.
- alloc[2][1] at t -> pl_allocated[2] = 1 at t+1 only; pl_free[2][1] = 0 from t+1; other lanes unchanged.
- Lane [0][0] allocated, 4 body flits sent -> credit_cnt 4->0, pl_credit[0][0] = 0. A 5th flit_sent -> err = 1, counter stays 0.
- Tail sent with credit_cnt = 2, then credit_in on 2 consecutive cycles -> DRAIN until the 2nd credit; pl_free[0][0] = 1 the cycle after. With LAG_PL_EARLY_RELEASE_EN, pl_free = 1 the cycle after the tail, while credit_cnt still reads 2.
- flit_sent and credit_in on the same cycle at credit_cnt = 3 -> stays 3, no err.
- alloc on a BUSY lane, and alloc with two bits set on one port -> err = 1, no state change, pl_allocated = 0 for that port.
